// File: rtl/frame_pkg.sv
// Frame buffer geometry and writer state encoding, shared by frame_writer and frame_displayer.
package frame_pkg;

  localparam int unsigned SCREEN_W     = 640;
  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned FRAME_ADDR_W = 19;
  localparam int unsigned FRAME_PIXELS = 307200;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_DRAW  = 2'd1,
    WR_FLUSH = 2'd2,
    WR_CLEAR = 2'd3
  } wr_state_t;

endpackage

// File: rtl/frame_addr_calc.sv
// Linear frame buffer address y*640 + x, built from shifts so no multiplier is needed.
module frame_addr_calc
  import frame_pkg::*;
(
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  output logic [FRAME_ADDR_W-1:0] addr
);

  logic [FRAME_ADDR_W-1:0] y_ext;
  logic [FRAME_ADDR_W-1:0] x_ext;

  always_comb begin
    y_ext = FRAME_ADDR_W'(y);
    x_ext = FRAME_ADDR_W'(x);
    addr  = (y_ext << 9) + (y_ext << 7) + x_ext;
  end

endmodule

// File: rtl/frame_writer.sv
// Sprite blitter / screen clearer on the frame buffer write port.
// Screen clear support is compiled in with `define FRAME_WRITER_CLEAR_EN.
module frame_writer
  import frame_pkg::*;
#(
  parameter int unsigned SPR_W       = 32,
  parameter int unsigned SPR_H       = 32,
  parameter int unsigned SPR_IDX_W   = 4,
  parameter logic [7:0]  TRANSPARENT = 8'h00
) (
  input  logic                                       Clk,
  input  logic                                       reset,
  input  logic                                       cmd_valid,
  output logic                                       cmd_ready,
  input  logic [9:0]                                 cmd_x,
  input  logic [9:0]                                 cmd_y,
  input  logic [SPR_IDX_W-1:0]                       cmd_sprite,
  input  logic                                       clear_req,
  input  logic [7:0]                                 clear_color,
  output logic [SPR_IDX_W+$clog2(SPR_W*SPR_H)-1:0]   spr_rdAddress,
  input  logic [7:0]                                 spr_data,
  output logic [FRAME_ADDR_W-1:0]                    frame_wrAddress,
  output logic [7:0]                                 frame_wrData,
  output logic                                       frame_we,
  output logic                                       busy,
  output logic                                       done
);

  localparam int unsigned COL_W = $clog2(SPR_W);
  localparam int unsigned ROW_W = $clog2(SPR_H);

  wr_state_t               state;
  logic [SPR_IDX_W-1:0]    spr_q;
  logic [ROW_W-1:0]        row_q;
  logic [COL_W-1:0]        col_q;
  logic [9:0]              x_q;
  logic [9:0]              y_q;
  logic [10:0]             px;
  logic [10:0]             py;
  logic                    on_screen;
  logic [FRAME_ADDR_W-1:0] pix_addr;
  logic                    wr_pend;
  logic                    vis_q;
  logic [FRAME_ADDR_W-1:0] wr_addr_q;
  logic                    accept_cmd;
  logic                    accept_clr;

  frame_addr_calc u_addr_calc (
    .x    (px[9:0]),
    .y    (py[9:0]),
    .addr (pix_addr)
  );

  // 11-bit sums keep off-screen pixels distinguishable instead of wrapping.
  always_comb begin
    px        = 11'(x_q) + 11'(col_q);
    py        = 11'(y_q) + 11'(row_q);
    on_screen = (px < 11'(SCREEN_W)) && (py < 11'(SCREEN_H));
  end

`ifdef FRAME_WRITER_CLEAR_EN
  logic [7:0] color_q;

  always_comb begin
    cmd_ready  = (state == WR_IDLE) && !clear_req;
    accept_clr = (state == WR_IDLE) && clear_req;
    accept_cmd = cmd_valid && cmd_ready;
  end
`else
  logic unused_clear;

  always_comb begin
    unused_clear = ^{clear_req, clear_color};
    cmd_ready    = (state == WR_IDLE);
    accept_clr   = 1'b0;
    accept_cmd   = cmd_valid && cmd_ready;
  end
`endif

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state     <= WR_IDLE;
      spr_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      wr_pend   <= 1'b0;
      vis_q     <= 1'b0;
      wr_addr_q <= '0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      wr_pend <= 1'b0;
      case (state)
        WR_IDLE: begin
          if (accept_clr) begin
            state     <= WR_CLEAR;
            wr_addr_q <= '0;
          end else if (accept_cmd) begin
            state <= WR_DRAW;
            spr_q <= cmd_sprite;
            x_q   <= cmd_x;
            y_q   <= cmd_y;
            row_q <= '0;
            col_q <= '0;
          end
        end
        WR_DRAW: begin
          // Address stage: register the target pixel; ROM data arrives next cycle.
          wr_pend   <= 1'b1;
          vis_q     <= on_screen;
          wr_addr_q <= pix_addr;
          col_q     <= col_q + 1'b1;
          if (&col_q) row_q <= row_q + 1'b1;
          if ((&col_q) && (&row_q)) state <= WR_FLUSH;
        end
        WR_FLUSH: begin
          state <= WR_IDLE;
          done  <= 1'b1;
        end
`ifdef FRAME_WRITER_CLEAR_EN
        WR_CLEAR: begin
          if (wr_addr_q == FRAME_ADDR_W'(FRAME_PIXELS - 1)) begin
            state <= WR_IDLE;
            done  <= 1'b1;
          end else begin
            wr_addr_q <= wr_addr_q + 1'b1;
          end
        end
`endif
        default: state <= WR_IDLE;
      endcase
    end
  end

`ifdef FRAME_WRITER_CLEAR_EN
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      color_q <= '0;
    end else if (accept_clr) begin
      color_q <= clear_color;
    end
  end
`endif

  always_comb begin
    busy            = (state != WR_IDLE);
    spr_rdAddress   = {spr_q, row_q, col_q};
    frame_wrAddress = wr_addr_q;
    frame_we        = wr_pend && vis_q && (spr_data != TRANSPARENT);
    frame_wrData    = wr_pend ? spr_data : '0;
`ifdef FRAME_WRITER_CLEAR_EN
    if (state == WR_CLEAR) begin
      frame_we     = 1'b1;
      frame_wrData = color_q;
    end
`endif
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Sprite blitter and screen clearer on the write side of the 640x480, 8-bit palette-index frame buffer. Accepts draw commands (sprite index, top-left x/y), streams the sprite's pixels from sprite ROM, and writes non-transparent, on-screen pixels into the frame buffer. The frame displayer reads the buffer through its own read port. Sits between game logic and the frame buffer write port.

## Interface
- SPR_W, 32, sprite width in pixels (power of 2)
- SPR_H, 32, sprite height in pixels (power of 2)
- SPR_IDX_W, 4, sprite-index width; ROM holds 2^SPR_IDX_W sprites
- TRANSPARENT, 8'h00, palette index that is never written
- Clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  draw command present
- cmd_ready  out  1  block idle and able to accept a command
- cmd_x  in  10  sprite top-left column
- cmd_y  in  10  sprite top-left row
- cmd_sprite  in  SPR_IDX_W  sprite index
- clear_req  in  1  fill the whole frame with clear_color (FRAME_WRITER_CLEAR_EN only)
- clear_color  in  8  fill palette index
- spr_rdAddress  out  SPR_IDX_W+log2(SPR_W*SPR_H)  sprite ROM read address = sprite*SPR_W*SPR_H + row*SPR_W + col
- spr_data  in  8  ROM data, valid one cycle after address
- frame_wrAddress  out  19  frame buffer write address = y*640 + x
- frame_wrData  out  8  write data
- frame_we  out  1  write strobe
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a draw or clear completes

## Operation
- States: IDLE, DRAW, FLUSH, CLEAR.
- IDLE: cmd_ready = !clear_req (combinational). clear_req wins over cmd_valid in the same cycle. Handshake: command captured when cmd_valid && cmd_ready.
- DRAW: row/col counters start at 0, col fastest. One ROM address issued per cycle; col wraps at SPR_W-1 and increments row. After address (SPR_H-1, SPR_W-1), go to FLUSH.
- Write stage (one cycle behind address stage, pipelined registers for px = x+col, py = y+row): frame_we = 1 only if spr_data != TRANSPARENT, px < 640 and py < 480. px/py computed at 11 bits so no wrap; off-screen pixels clip, never wrap to the next row.
- FLUSH: performs the final write stage, pulses done, returns to IDLE.
- CLEAR: address counts 0..307199, frame_we = 1 and frame_wrData = clear_color every cycle; after 307199, done pulses, IDLE. clear_color sampled at acceptance.
- cmd_valid is ignored while busy; no queueing.
- Reset (any time, mid-draw included): FSM to IDLE immediately; already-written pixels stay in the buffer.
- Reset values: frame_we 0, frame_wrAddress 0, frame_wrData 0, spr_rdAddress 0, done 0, busy 0; cmd_ready follows IDLE rule.

## Timing
- Command accepted in cycle T: first ROM address at T+1, first possible write at T+2, last write at T+1+SPR_W*SPR_H (T+1025 default), done and cmd_ready high at T+2+SPR_W*SPR_H; next accept possible that cycle.
- Clear accepted in T: writes T+1..T+307200, done at T+307201.
- frame_wrAddress/frame_wrData/frame_we are registered; the buffer samples them on the next Clk edge.
- ROM latency is exactly 1 cycle; no stalls are supported.

## Configuration
- FRAME_WRITER_CLEAR_EN defined: CLEAR state, clear_req and clear_color are functional.
- Not defined: ports remain, but clear_req and clear_color are ignored, CLEAR state does not exist, and cmd_ready = (state == IDLE).

## Structure
- frame_pkg: SCREEN_W = 640, SCREEN_H = 480, FRAME_ADDR_W = 19, FRAME_PIXELS = 307200, the writer state enum typedef. Shared with frame_displayer.
- Sub-module frame_addr_calc: combinational y*640 + x computed as (y<<9)+(y<<7)+x, 19-bit. Also reused by the displayer.

## Test plan
- Sprite 2 at (100,50), ROM all 8'h07 -> exactly 1024 writes, first address 50*640+100 = 32100, last 81*640+131 = 51971, done at T+1026.
- ROM checkerboard with 8'h00 -> 512 writes, no write where data = 8'h00.
- Sprite at (620,470) -> only cols 620..639 and rows 470..479 written (200 writes); no address >= 307200; done still at T+1026.
- clear_req and cmd_valid in the same IDLE cycle, color 8'h52 -> clear runs, 307200 writes of 8'h52, then done; command then accepted on re-assertion.
- reset asserted at T+300 during a draw -> frame_we 0, busy 0 immediately; a new command is accepted after release.
- Back-to-back commands held valid -> second accept in the done cycle; no gap writes, no duplicate addresses.
